// File: rtl/dec_pkg.sv
// Shared types and helpers for the one-hot decoder with skid buffer.
//   occ_e       : buffer occupancy state (EMPTY / ONE / TWO)
//   out_w()     : one-hot width for a given code width (2**w)
//   dec_entry_t : {onehot, code} entry at the default code width DEC_W
package dec_pkg;

    localparam int DEC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    function automatic int out_w(input int w);
        return 1 << w;
    endfunction

    typedef struct packed {
        logic [(1 << DEC_W)-1:0] onehot;
        logic [DEC_W-1:0]        code;
    } dec_entry_t;

endpackage

// File: rtl/dec_onehot_core.sv
// Combinational binary-to-one-hot decoder with enable.
// Ports:
//   i_code   (W)       binary code
//   i_en     (1)       enable; 0 forces all-zero onehot and zero code
//   o_onehot (2**W)    one-hot select, bit i_code set when enabled
//   o_code   (W)       code passed through when enabled, else 0
module dec_onehot_core
    import dec_pkg::*;
#(
    parameter int W = 2
)(
    input  logic [W-1:0]           i_code,
    input  logic                   i_en,
    output logic [out_w(W)-1:0]    o_onehot,
    output logic [W-1:0]           o_code
);

    localparam int OUT_W = out_w(W);

    always_comb begin
        o_onehot = '0;
        o_code   = '0;
        if (i_en) begin
            o_onehot = OUT_W'(1) << i_code;
            o_code   = i_code;
        end
    end

endmodule

// File: rtl/dec_onehot_skid.sv
// Binary-to-one-hot decoder with valid/ready on both sides and a 2-entry
// skid buffer (main register drives the outputs, skid register behind it).
// in_ready and out_valid come straight from flops.
// Optional hit counters are built when the macro DEC_STATS_EN is defined.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake
//   in_code (W), in_en      code and decode enable
//   out_valid/out_ready     output handshake
//   out_onehot (2**W)       decoded select
//   out_code (W)            code carried alongside (0 when en=0)
//   stat_clr                synchronous counter clear (DEC_STATS_EN only)
//   stat_hits (2**W*STAT_W) packed per-line counters (DEC_STATS_EN only)
module dec_onehot_skid
    import dec_pkg::*;
#(
    parameter int W = 2
`ifdef DEC_STATS_EN
    , parameter int STAT_W = 8
`endif
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_code,
    input  logic                         in_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [out_w(W)-1:0]          out_onehot,
    output logic [W-1:0]                 out_code
`ifdef DEC_STATS_EN
    , input  logic                         stat_clr
    , output logic [out_w(W)*STAT_W-1:0]   stat_hits
`endif
);

    localparam int OUT_W = out_w(W);

    typedef struct packed {
        logic [OUT_W-1:0] onehot;
        logic [W-1:0]     code;
    } entry_t;

    occ_e   r_state, w_state_nxt;
    entry_t r_main, r_skid, w_main_nxt, w_dec;
    logic   r_in_ready, r_out_valid;
    logic   w_push, w_pop, w_skid_load;

    dec_onehot_core #(.W(W)) u_core (
        .i_code   (in_code),
        .i_en     (in_en),
        .o_onehot (w_dec.onehot),
        .o_code   (w_dec.code)
    );

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    // Occupancy FSM; the main register is cleared when the buffer drains so
    // the outputs read zero whenever out_valid is low.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_load = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_state_nxt = ONE;
                    w_main_nxt  = w_dec;
                end else begin
                    w_main_nxt  = '0;
                end
            end
            ONE: begin
                if (w_push && w_pop) begin
                    w_main_nxt  = w_dec;
                end else if (w_push) begin
                    w_state_nxt = TWO;
                    w_skid_load = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = '0;
                end
            end
            TWO: begin
                if (w_pop) begin
                    w_state_nxt = ONE;
                    w_main_nxt  = r_skid;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
                w_main_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != TWO);
            r_out_valid <= (w_state_nxt != EMPTY);
            r_main      <= w_main_nxt;
            if (w_skid_load) begin
                r_skid <= w_dec;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_onehot = r_main.onehot;
    assign out_code   = r_main.code;

`ifdef DEC_STATS_EN
    // Per-line saturating hit counters; clear takes priority over a hit.
    for (genvar i = 0; i < OUT_W; i++) begin : g_hits
        logic [STAT_W-1:0] r_hits;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hits <= '0;
            end else if (stat_clr) begin
                r_hits <= '0;
            end else if (w_pop && r_main.onehot[i] && (r_hits != {STAT_W{1'b1}})) begin
                r_hits <= r_hits + 1'b1;
            end
        end
        assign stat_hits[i*STAT_W +: STAT_W] = r_hits;
    end
`endif

endmodule
